// File: rtl/pc_sel_chk_pkg.sv
// rtl/pc_sel_chk_pkg.sv - shared types and constants for the thread-PC select checker
package pc_sel_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FAILED = 2'd2
    } chk_state_e;

    localparam int ERR_CNT_W = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};
    localparam int CONS_W = 8;

    localparam int DEF_NUM_THR    = 4;
    localparam int DEF_PC_W       = 48;
    localparam int DEF_ERR_THRESH = 1;
    localparam int DEF_CORE_W     = 10;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_sel_chk_enc.sv
// rtl/pc_sel_chk_enc.sv - lowest-set-bit index of the thread select, plus one-hot flag
// One-hot flag port exists only with PC_SEL_CHK_ONEHOT_CHK_EN defined.
module pc_sel_chk_enc #(
    parameter int NUM_THR = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_THR-1:0] thr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
`ifdef PC_SEL_CHK_ONEHOT_CHK_EN
    ,
    output logic               onehot_o
`endif
);

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        idx_o = '0;
        for (int i = NUM_THR - 1; i >= 0; i--) begin
            if (thr_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign any_o = |thr_i;

`ifdef PC_SEL_CHK_ONEHOT_CHK_EN
    assign onehot_o = any_o && ((thr_i & (thr_i - NUM_THR'(1))) == '0);
`endif

endmodule

// File: rtl/pc_sel_chk_mon.sv
// rtl/pc_sel_chk_mon.sv - checks the muxed F-stage PC against the selected thread PC
// Optional select-encoding check enabled by PC_SEL_CHK_ONEHOT_CHK_EN.
module pc_sel_chk_mon
    import pc_sel_chk_pkg::*;
#(
    parameter int NUM_THR    = DEF_NUM_THR,
    parameter int PC_W       = DEF_PC_W,
    parameter int ERR_THRESH = DEF_ERR_THRESH,
    parameter int CORE_W     = DEF_CORE_W
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        chk_en,
    input  logic                        inst_vld_f,
    input  logic                        running_s,
    input  logic [NUM_THR-1:0]          thr_f,
    input  logic [PC_W-1:0]             pc_f,
    input  logic [NUM_THR*PC_W-1:0]     thr_pc_f,
    input  logic [CORE_W-1:0]           coreid,
    output logic                        err_o,
    output logic                        fail_o,
    output logic                        sel_err_o,
    output logic [ERR_CNT_W-1:0]        err_cnt_o,
    output logic [idx_w(NUM_THR)-1:0]   first_thr_o,
    output logic [PC_W-1:0]             first_pc_o,
    output logic [PC_W-1:0]             first_exp_o,
    output logic [CORE_W-1:0]           first_core_o
);

    localparam int IDX_W = idx_w(NUM_THR);
    localparam logic [CONS_W-1:0] THRESH = CONS_W'(ERR_THRESH);

    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic [PC_W-1:0]  exp_pc;
    logic             chk;
    logic             mism;

    chk_state_e state_q, state_d;

    logic                 err_q;
    logic [CONS_W-1:0]    cons_q, cons_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 first_seen_q;
    logic [IDX_W-1:0]     first_thr_q;
    logic [PC_W-1:0]      first_pc_q;
    logic [PC_W-1:0]      first_exp_q;
    logic [CORE_W-1:0]    first_core_q;

`ifdef PC_SEL_CHK_ONEHOT_CHK_EN
    logic sel_onehot;
    logic sel_err_q;
`endif

    pc_sel_chk_enc #(
        .NUM_THR (NUM_THR),
        .IDX_W   (IDX_W)
    ) u_enc (
        .thr_i    (thr_f),
        .idx_o    (sel_idx),
        .any_o    (sel_any)
`ifdef PC_SEL_CHK_ONEHOT_CHK_EN
        ,
        .onehot_o (sel_onehot)
`endif
    );

    assign exp_pc = thr_pc_f[32'(sel_idx) * PC_W +: PC_W];
    assign chk    = chk_en && inst_vld_f && running_s && sel_any;
    assign mism   = chk && (pc_f != exp_pc);

    // Consecutive-mismatch run length; saturates at the failure threshold.
    always_comb begin
        cons_d = cons_q;
        if (mism) begin
            if (cons_q != THRESH) begin
                cons_d = cons_q + CONS_W'(1);
            end
        end else if (chk) begin
            cons_d = '0;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (mism && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (chk_en) begin
                    state_d = (mism && (cons_d == THRESH)) ? ST_FAILED : ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!chk_en) begin
                    state_d = ST_IDLE;
                end else if (mism && (cons_d == THRESH)) begin
                    state_d = ST_FAILED;
                end
            end
            ST_FAILED: state_d = ST_FAILED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fail_o = (state_q == ST_FAILED);
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            err_q        <= 1'b0;
            cons_q       <= '0;
            err_cnt_q    <= '0;
            first_seen_q <= 1'b0;
            first_thr_q  <= '0;
            first_pc_q   <= '0;
            first_exp_q  <= '0;
            first_core_q <= '0;
        end else begin
            err_q     <= mism;
            cons_q    <= cons_d;
            err_cnt_q <= err_cnt_d;
            // Capture record is written once per reset and then frozen.
            if (mism && !first_seen_q) begin
                first_seen_q <= 1'b1;
                first_thr_q  <= sel_idx;
                first_pc_q   <= pc_f;
                first_exp_q  <= exp_pc;
                first_core_q <= coreid;
            end
        end
    end

`ifdef PC_SEL_CHK_ONEHOT_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            sel_err_q <= 1'b0;
        end else if (chk_en && inst_vld_f && running_s && !sel_onehot) begin
            sel_err_q <= 1'b1;
        end
    end
    assign sel_err_o = sel_err_q;
`else
    assign sel_err_o = 1'b0;
`endif

    assign err_o        = err_q;
    assign err_cnt_o    = err_cnt_q;
    assign first_thr_o  = first_thr_q;
    assign first_pc_o   = first_pc_q;
    assign first_exp_o  = first_exp_q;
    assign first_core_o = first_core_q;

endmodule

// File: tb/tb_pc_sel_chk_mon.sv
// tb/tb_pc_sel_chk_mon.sv - directed self-checking bench for pc_sel_chk_mon
module tb_pc_sel_chk_mon;

    localparam int NT = 4;
    localparam int PW = 48;
    localparam int CW = 10;

`ifdef PC_SEL_CHK_ONEHOT_CHK_EN
    localparam logic SEL_EXP = 1'b1;
`else
    localparam logic SEL_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_l;
    logic             chk_en;
    logic             inst_vld_f;
    logic             running_s;
    logic [NT-1:0]    thr_f;
    logic [PW-1:0]    pc_f;
    logic [NT*PW-1:0] thr_pc_f;
    logic [CW-1:0]    coreid;

    logic          a_err, a_fail, a_sel_err;
    logic [15:0]   a_cnt;
    logic [1:0]    a_fthr;
    logic [PW-1:0] a_fpc, a_fexp;
    logic [CW-1:0] a_fcore;

    logic          b_err, b_fail, b_sel_err;
    logic [15:0]   b_cnt;
    logic [1:0]    b_fthr;
    logic [PW-1:0] b_fpc, b_fexp;
    logic [CW-1:0] b_fcore;

    int tests_run    = 0;
    int tests_failed = 0;

    pc_sel_chk_mon #(.NUM_THR(NT), .PC_W(PW), .ERR_THRESH(1), .CORE_W(CW)) u_t1 (
        .clk(clk), .rst_l(rst_l), .chk_en(chk_en), .inst_vld_f(inst_vld_f),
        .running_s(running_s), .thr_f(thr_f), .pc_f(pc_f), .thr_pc_f(thr_pc_f),
        .coreid(coreid), .err_o(a_err), .fail_o(a_fail), .sel_err_o(a_sel_err),
        .err_cnt_o(a_cnt), .first_thr_o(a_fthr), .first_pc_o(a_fpc),
        .first_exp_o(a_fexp), .first_core_o(a_fcore)
    );

    pc_sel_chk_mon #(.NUM_THR(NT), .PC_W(PW), .ERR_THRESH(3), .CORE_W(CW)) u_t3 (
        .clk(clk), .rst_l(rst_l), .chk_en(chk_en), .inst_vld_f(inst_vld_f),
        .running_s(running_s), .thr_f(thr_f), .pc_f(pc_f), .thr_pc_f(thr_pc_f),
        .coreid(coreid), .err_o(b_err), .fail_o(b_fail), .sel_err_o(b_sel_err),
        .err_cnt_o(b_cnt), .first_thr_o(b_fthr), .first_pc_o(b_fpc),
        .first_exp_o(b_fexp), .first_core_o(b_fcore)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [PW-1:0] seq_pc   [6] = '{48'h2004, 48'h2004, 48'h2000, 48'h2004, 48'h2004, 48'h2004};
    logic          seq_fail [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic          seq_err  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst_l      = 1'b0;
        chk_en     = 1'b0;
        inst_vld_f = 1'b0;
        running_s  = 1'b0;
        thr_f      = '0;
        pc_f       = '0;
        coreid     = '0;
        thr_pc_f   = {48'h3000, 48'h1000, 48'h2000, 48'h0500};
        step();
        step();

        check_eq("rst_err",     64'(a_err), 64'd0);
        check_eq("rst_fail",    64'(a_fail), 64'd0);
        check_eq("rst_sel_err", 64'(a_sel_err), 64'd0);
        check_eq("rst_cnt",     64'(a_cnt), 64'd0);
        check_eq("rst_fthr",    64'(a_fthr), 64'd0);
        check_eq("rst_fpc",     64'(a_fpc), 64'd0);
        check_eq("rst_fexp",    64'(a_fexp), 64'd0);
        check_eq("rst_fcore",   64'(a_fcore), 64'd0);
        check_eq("rst_fail_t3", 64'(b_fail), 64'd0);

        rst_l      = 1'b1;
        chk_en     = 1'b1;
        inst_vld_f = 1'b1;
        running_s  = 1'b1;
        thr_f      = 4'b0100;
        pc_f       = 48'h1000;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("match_err", 64'(a_err), 64'd0);
        end
        check_eq("match_cnt",  64'(a_cnt), 64'd0);
        check_eq("match_fail", 64'(a_fail), 64'd0);

        thr_f  = 4'b0010;
        pc_f   = 48'h2004;
        coreid = 10'd5;
        step();
        check_eq("mm_err",     64'(a_err), 64'd1);
        check_eq("mm_fail",    64'(a_fail), 64'd1);
        check_eq("mm_fthr",    64'(a_fthr), 64'd1);
        check_eq("mm_fpc",     64'(a_fpc), 64'h2004);
        check_eq("mm_fexp",    64'(a_fexp), 64'h2000);
        check_eq("mm_fcore",   64'(a_fcore), 64'd5);
        check_eq("mm_cnt",     64'(a_cnt), 64'd1);
        check_eq("mm_fail_t3", 64'(b_fail), 64'd0);

        inst_vld_f = 1'b0;
        step();
        check_eq("pulse_end_err",  64'(a_err), 64'd0);
        check_eq("pulse_end_fail", 64'(a_fail), 64'd1);

        inst_vld_f = 1'b1;
        thr_f      = 4'b0001;
        pc_f       = 48'h0777;
        coreid     = 10'd9;
        step();
        check_eq("failed_err",   64'(a_err), 64'd1);
        check_eq("failed_cnt",   64'(a_cnt), 64'd2);
        check_eq("frozen_fthr",  64'(a_fthr), 64'd1);
        check_eq("frozen_fpc",   64'(a_fpc), 64'h2004);
        check_eq("frozen_fcore", 64'(a_fcore), 64'd5);

        thr_f = 4'b0110;
        pc_f  = 48'h2000;
        step();
        check_eq("multihot_err", 64'(a_err), 64'd0);
        check_eq("multihot_cnt", 64'(a_cnt), 64'd2);
        check_eq("multihot_sel", 64'(a_sel_err), 64'(SEL_EXP));

        thr_f = 4'b0000;
        pc_f  = 48'h9999;
        step();
        check_eq("zerohot_err", 64'(a_err), 64'd0);
        check_eq("zerohot_cnt", 64'(a_cnt), 64'd2);
        check_eq("zerohot_sel", 64'(a_sel_err), 64'(SEL_EXP));

        rst_l = 1'b0;
        step();
        rst_l  = 1'b1;
        chk_en = 1'b0;
        check_eq("rerst_fail",  64'(a_fail), 64'd0);
        check_eq("rerst_err",   64'(a_err), 64'd0);
        check_eq("rerst_cnt",   64'(a_cnt), 64'd0);
        check_eq("rerst_fpc",   64'(a_fpc), 64'd0);
        check_eq("rerst_fcore", 64'(a_fcore), 64'd0);
        check_eq("rerst_sel",   64'(a_sel_err), 64'd0);

        thr_f = 4'b0010;
        pc_f  = 48'h2004;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("dis_err", 64'(a_err), 64'd0);
        end
        check_eq("dis_cnt",  64'(a_cnt), 64'd0);
        check_eq("dis_fail", 64'(a_fail), 64'd0);

        chk_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pc_f = seq_pc[i];
            step();
            check_eq("t3_err",  64'(b_err), 64'(seq_err[i]));
            check_eq("t3_fail", 64'(b_fail), 64'(seq_fail[i]));
        end
        check_eq("t3_cnt",  64'(b_cnt), 64'd5);
        check_eq("t3_fthr", 64'(b_fthr), 64'd1);

        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        pc_f  = 48'h2004;
        for (int i = 0; i < 65534; i++) begin
            step();
        end
        check_eq("sat_pre", 64'(a_cnt), 64'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("sat_cnt", 64'(a_cnt), 64'hFFFF);
            check_eq("sat_err", 64'(a_err), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_sel_chk_mon.md
PC_SEL_CHK_MON -- requirements
Module: pc_sel_chk_mon

Interface
REQ-001 The block SHALL take parameter NUM_THR, default 4, as the number of thread PC channels checked (legal 1..64).
REQ-002 The block SHALL take parameter PC_W, default 48, as the PC width in bits.
REQ-003 The block SHALL take parameter ERR_THRESH, default 1, as the count of consecutive mismatching checks that declares failure (legal 1..255).
REQ-004 The block SHALL take parameter CORE_W, default 10, as the width of the core id.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst_l  in  1  reset, synchronous and active-low.
REQ-007 chk_en  in  1  run-time check enable; 0 suspends checking.
REQ-008 inst_vld_f  in  1  F-stage instruction valid.
REQ-009 running_s  in  1  selected thread running.
REQ-010 thr_f  in  NUM_THR  F-stage thread select, expected one-hot.
REQ-011 pc_f  in  PC_W  muxed F-stage PC.
REQ-012 thr_pc_f  in  NUM_THR*PC_W  per-thread PCs; thread i occupies bits [i*PC_W +: PC_W].
REQ-013 coreid  in  CORE_W  core id, carried only into the capture record.
REQ-014 err_o  out  1  one-cycle pulse for each mismatching check.
REQ-015 fail_o  out  1  sticky failure flag.
REQ-016 sel_err_o  out  1  sticky thread-select encoding error.
REQ-017 err_cnt_o  out  16  total mismatch count, saturating.
REQ-018 first_thr_o  out  clog2(NUM_THR) (min 1)  thread of the first mismatch.
REQ-019 first_pc_o / first_exp_o  out  PC_W each  pc_f and expected PC at the first mismatch.
REQ-020 first_core_o  out  CORE_W  coreid at the first mismatch.

Function
REQ-021 A check SHALL occur on a rising edge where rst_l=1, chk_en=1, inst_vld_f=1, running_s=1 and thr_f!=0.
- sel = lowest set bit of thr_f.
- mismatch = (pc_f != thr_pc_f[sel]).
REQ-022 State machine SHALL have states IDLE, ARMED and FAILED.
- IDLE->ARMED on the first edge with chk_en=1.
- ARMED->FAILED when the consecutive count reaches ERR_THRESH.
- FAILED is terminal until reset.
- chk_en=0 in ARMED returns the machine to IDLE and holds all counters.
REQ-023 err_o SHALL rise in the cycle after a mismatching check and last exactly one cycle (latency 1), in ARMED and in FAILED alike.
REQ-024 The consecutive counter SHALL behave as follows:
- increments on a mismatching check;
- clears on a matching check;
- holds on non-check cycles;
- saturates at ERR_THRESH.
REQ-025 fail_o SHALL assert in the same cycle as the err_o pulse that brings the count to ERR_THRESH; with ERR_THRESH=1 the first mismatch sets fail_o.
REQ-026 err_cnt_o SHALL increment by 1 per mismatch and hold at 16'hFFFF.
REQ-027 The first_* outputs SHALL load only on the first mismatch after reset and then freeze, including in FAILED.
REQ-028 Multi-hot thr_f SHALL still be checked against the lowest set bit.
REQ-029 An all-zero thr_f with inst_vld_f & running_s SHALL perform no PC check.

Reset
REQ-030 While rst_l=0 at a rising edge, the block SHALL enter the following reset state:
- state = IDLE;
- err_o, fail_o and sel_err_o = 0;
- err_cnt_o and the consecutive counter = 0;
- first_* outputs = 0.
REQ-031 Reset asserted mid-operation, including in FAILED, SHALL take effect at the next edge and discard all history.

Configuration
REQ-032 With PC_SEL_CHK_ONEHOT_CHK_EN defined, sel_err_o SHALL set, sticky, one cycle after any edge with inst_vld_f & running_s & chk_en and thr_f not exactly one-hot (zero-hot or multi-hot).
REQ-033 Without PC_SEL_CHK_ONEHOT_CHK_EN, sel_err_o SHALL be tied 0 and no encoding logic SHALL be present.

Structure
REQ-034 Package pc_sel_chk_pkg SHALL hold:
- the state enum (IDLE/ARMED/FAILED);
- the ERR_CNT_W=16 constant;
- the default parameter constants.
REQ-035 Sub-module pc_sel_chk_enc SHALL compute the lowest-set index and the one-hot-valid flag from thr_f for any NUM_THR.

Verification
REQ-036 NUM_THR=4, ERR_THRESH=1, thr_f=4'b0100, pc_f=thr_pc_f[2]=48'h1000 for 10 checks -> err_o never asserts, err_cnt_o=0, fail_o=0.
REQ-037 thr_f=4'b0010, pc_f=48'h2004, thr_pc_f[1]=48'h2000, coreid=5 -> err_o pulses the next cycle, fail_o=1, first_thr_o=1, first_pc_o=48'h2004, first_exp_o=48'h2000, first_core_o=5.
REQ-038 ERR_THRESH=3, mismatch, mismatch, match, mismatch x3 -> fail_o sets only on the 3rd consecutive mismatch; err_cnt_o=5.
REQ-039 Macro defined, thr_f=4'b0110 with pc_f=thr_pc_f[1] -> sel_err_o=1, no err_o; thr_f=0 -> sel_err_o=1 and no PC check.
REQ-040 Preload err_cnt_o to 16'hFFFE, 3 mismatches -> err_cnt_o holds at 16'hFFFF.
REQ-041 FAILED state, drop rst_l for one edge -> all outputs 0 next cycle; chk_en=0 with mismatching inputs -> no err_o.
